// File: rtl/time_keeper.sv
// Time-of-day clock with hh:mm edit FSM and single alarm; optional alarm
// auto-silence after 60 ticks when ALARM_TIMEOUT_EN is defined.
module time_keeper #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic [16:0] disp_time,
  output logic [1:0]  edit_sel,
  output logic        alarm_view,
  output logic        alarm
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ - 1);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] SET_HH = 3'd1;
  localparam logic [2:0] SET_MM = 3'd2;
  localparam logic [2:0] ALM_HH = 3'd3;
  localparam logic [2:0] ALM_MM = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hh_q, hh_d, ahh_q, ahh_d;
  logic [5:0]    mm_q, mm_d, ss_q, ss_d, amm_q, amm_d;
  logic [16:0]   disp_q, disp_d;
  logic          alarm_q, alarm_d;
  logic          setting, tick, leave_set_mm, trigger;
`ifdef ALARM_TIMEOUT_EN
  logic [5:0]    to_q, to_d;
`endif

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    if (mode_btn) begin
      case (state_q)
        RUN:     state_d = SET_HH;
        SET_HH:  state_d = SET_MM;
        SET_MM:  state_d = ALM_HH;
        ALM_HH:  state_d = ALM_MM;
        default: state_d = RUN;
      endcase
    end

    setting      = (state_q == SET_HH) || (state_q == SET_MM);
    tick         = !setting && (presc_q == PRESC_TC);
    leave_set_mm = mode_btn && (state_q == SET_MM);

    if ((state_d == SET_HH) || (state_d == SET_MM) || leave_set_mm || tick)
      presc_d = '0;
    else
      presc_d = presc_q + 1'b1;

    hh_d  = hh_q;
    mm_d  = mm_q;
    ss_d  = ss_q;
    ahh_d = ahh_q;
    amm_d = amm_q;
    if (tick) begin
      ss_d = inc_mod60(ss_q);
      if (ss_q == 6'd59) begin
        mm_d = inc_mod60(mm_q);
        if (mm_q == 6'd59) hh_d = inc_mod24(hh_q);
      end
    end
    // A simultaneous mode press wins; the increment is dropped.
    if (inc_btn && !mode_btn) begin
      case (state_q)
        SET_HH:  hh_d  = inc_mod24(hh_q);
        SET_MM:  mm_d  = inc_mod60(mm_q);
        ALM_HH:  ahh_d = inc_mod24(ahh_q);
        ALM_MM:  amm_d = inc_mod60(amm_q);
        default: ;
      endcase
    end
    if (leave_set_mm) ss_d = 6'd0;

    trigger = (state_q == RUN) && alarm_en && tick &&
              ({hh_d, mm_d, ss_d} == {ahh_q, amm_q, 6'd0});

    alarm_d = alarm_q;
`ifdef ALARM_TIMEOUT_EN
    to_d = to_q;
    if (trigger) to_d = 6'd0;
    else if (alarm_q && tick) to_d = to_q + 6'd1;
`endif
    if (trigger)
      alarm_d = 1'b1;
    else if (alarm_ack || !alarm_en)
      alarm_d = 1'b0;
`ifdef ALARM_TIMEOUT_EN
    else if (alarm_q && tick && (to_q == 6'd59))
      alarm_d = 1'b0;
`endif

    if ((state_d == ALM_HH) || (state_d == ALM_MM))
      disp_d = {ahh_d, amm_d, 6'd0};
    else
      disp_d = {hh_d, mm_d, ss_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      presc_q <= '0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      ahh_q   <= '0;
      amm_q   <= '0;
      disp_q  <= '0;
      alarm_q <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      ahh_q   <= ahh_d;
      amm_q   <= amm_d;
      disp_q  <= disp_d;
      alarm_q <= alarm_d;
`ifdef ALARM_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign disp_time  = disp_q;
  assign alarm      = alarm_q;
  assign alarm_view = (state_q == ALM_HH) || (state_q == ALM_MM);
  assign edit_sel   = ((state_q == SET_HH) || (state_q == ALM_HH)) ? 2'b01 :
                      ((state_q == SET_MM) || (state_q == ALM_MM)) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper at CLK_FREQ=4: vector table through a scoreboard
// queue, then hand-written alarm, wrap, collision and reset sequences.
module tb_time_keeper;

  logic        clk = 1'b0;
  logic        reset, mode_btn, inc_btn, alarm_en, alarm_ack;
  logic [16:0] disp_time;
  logic [1:0]  edit_sel;
  logic        alarm_view, alarm;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        mode;
    logic        inc;
    int          cycles;
    logic [16:0] disp;
    logic [1:0]  sel;
    logic        view;
    logic        alm;
  } vec_t;

  vec_t tbl[18];
  vec_t exp_q[$];

  time_keeper #(.CLK_FREQ(4)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack), .disp_time(disp_time),
    .edit_sel(edit_sel), .alarm_view(alarm_view), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic m, input logic i, input int c,
                              input logic [16:0] d, input logic [1:0] s,
                              input logic v, input logic a);
    vec_t r;
    r.mode = m; r.inc = i; r.cycles = c; r.disp = d; r.sel = s; r.view = v; r.alm = a;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i, input logic a);
    mode_btn = m; inc_btn = i; alarm_ack = a;
    cyc();
    mode_btn = 0; inc_btn = 0; alarm_ack = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    vec_t e;
    mode_btn = v.mode; inc_btn = v.inc;
    exp_q.push_back(v);
    cyc();
    mode_btn = 0; inc_btn = 0;
    repeat (v.cycles - 1) cyc();
    e = exp_q.pop_front();
    check($sformatf("row%0d_disp", idx), 32'(disp_time), 32'(e.disp));
    check($sformatf("row%0d_sel", idx), 32'(edit_sel), 32'(e.sel));
    check($sformatf("row%0d_view", idx), 32'(alarm_view), 32'(e.view));
    check($sformatf("row%0d_alarm", idx), 32'(alarm), 32'(e.alm));
  endtask

  // Program alarm 00:01 from a fresh reset and return to RUN.
  task automatic setup_alarm_0001();
    do_reset();
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
  endtask

  initial begin
    int n;
    logic found;
    logic prev_alarm;

    reset = 1; mode_btn = 0; inc_btn = 0; alarm_en = 0; alarm_ack = 0;
    tbl[0]  = mk(0, 0, 3,  17'h00000, 2'd0, 0, 0);
    tbl[1]  = mk(0, 0, 1,  17'h00001, 2'd0, 0, 0);
    tbl[2]  = mk(1, 0, 1,  17'h00001, 2'd1, 0, 0);
    tbl[3]  = mk(0, 1, 1,  17'h01001, 2'd1, 0, 0);
    tbl[4]  = mk(0, 1, 1,  17'h02001, 2'd1, 0, 0);
    tbl[5]  = mk(0, 1, 1,  17'h03001, 2'd1, 0, 0);
    tbl[6]  = mk(0, 0, 10, 17'h03001, 2'd1, 0, 0);
    tbl[7]  = mk(1, 0, 1,  17'h03001, 2'd2, 0, 0);
    tbl[8]  = mk(0, 1, 1,  17'h03041, 2'd2, 0, 0);
    tbl[9]  = mk(0, 1, 1,  17'h03081, 2'd2, 0, 0);
    tbl[10] = mk(1, 0, 1,  17'h00000, 2'd1, 1, 0);
    tbl[11] = mk(0, 0, 4,  17'h00000, 2'd1, 1, 0);
    tbl[12] = mk(0, 1, 1,  17'h01000, 2'd1, 1, 0);
    tbl[13] = mk(1, 0, 1,  17'h01000, 2'd2, 1, 0);
    tbl[14] = mk(0, 1, 1,  17'h01040, 2'd2, 1, 0);
    tbl[15] = mk(1, 0, 1,  17'h03082, 2'd0, 0, 0);
    tbl[16] = mk(0, 1, 1,  17'h03082, 2'd0, 0, 0);
    tbl[17] = mk(0, 0, 3,  17'h03083, 2'd0, 0, 0);

    cyc(); cyc();
    reset = 0;
    check("rst_disp", 32'(disp_time), 0);
    check("rst_sel", 32'(edit_sel), 0);
    check("rst_view", 32'(alarm_view), 0);
    check("rst_alarm", 32'(alarm), 0);

    for (int i = 0; i < 18; i++) run_row(tbl[i], i);

    // Mode and inc together in SET_HH, then reset mid-edit.
    do_reset();
    pulse(1, 0, 0);
    check("c_sel_hh", 32'(edit_sel), 1);
    pulse(1, 1, 0);
    check("c_sel_mm", 32'(edit_sel), 2);
    check("c_hh_keep", 32'(disp_time), 0);
    pulse(0, 1, 0);
    check("c_mm_inc", 32'(disp_time), 32'h00040);
    reset = 1; mode_btn = 1; inc_btn = 1;
    cyc();
    reset = 0; mode_btn = 0; inc_btn = 0;
    check("c_rst_disp", 32'(disp_time), 0);
    check("c_rst_sel", 32'(edit_sel), 0);

    // Hours wrap in edit, then 23:59:59 rolling over to midnight.
    do_reset();
    pulse(1, 0, 0);
    repeat (24) pulse(0, 1, 0);
    check("w_hh_wrap", 32'(disp_time), 0);
    repeat (23) pulse(0, 1, 0);
    pulse(1, 0, 0);
    repeat (59) pulse(0, 1, 0);
    check("w_2359", 32'(disp_time), 32'h17EC0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      cyc();
      if (disp_time == 17'h17EFB) found = 1;
    end
    check("w_reach_235959", 32'(found), 1);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      cyc();
      if (disp_time != 17'h17EFB) found = 1;
    end
    check("w_rollover_seen", 32'(found), 1);
    check("w_midnight", 32'(disp_time), 0);

    // Alarm 00:01 triggers on the 60th tick; ack clears it.
    alarm_en = 1;
    setup_alarm_0001();
    found = 0; n = 0; prev_alarm = 0;
    while (!found && n < 400) begin
      prev_alarm = alarm;
      cyc();
      n++;
      if (alarm) found = 1;
    end
    check("a_trig_seen", 32'(found), 1);
    check("a_trig_cycle", 32'(n), 237);
    check("a_prev_low", 32'(prev_alarm), 0);
    check("a_trig_time", 32'(disp_time), 32'h00040);
    pulse(0, 0, 1);
    check("a_ack_clear", 32'(alarm), 0);
    repeat (8) cyc();
    check("a_stay_low", 32'(alarm), 0);

    // Ack in the trigger cycle loses to the trigger.
    setup_alarm_0001();
    repeat (236) cyc();
    check("b_pre_trig", 32'(alarm), 0);
    pulse(0, 0, 1);
    check("b_trig_wins", 32'(alarm), 1);
`ifdef ALARM_TIMEOUT_EN
    repeat (239) cyc();
    check("t_before_to", 32'(alarm), 1);
    cyc();
    check("t_timeout", 32'(alarm), 0);
`else
    repeat (480) cyc();
    check("t_no_timeout", 32'(alarm), 1);
    pulse(1, 0, 0);
    check("t_persist_fsm", 32'(alarm), 1);
    alarm_en = 0;
    cyc();
    check("t_en_clear", 32'(alarm), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
